micro_mc: RTL and testbench
===========================

// Module: micro_mc
// PURPOSE
//  Parametrised multi-cycle successor of the lab microcontroller. Fetches 16-bit instructions from an external
//  synchronous IRAM, executes from a 16-entry register file with an ALU and N/Z/C/V flags.
//  Adds conditional branches, a hardware call/return stack, a WAIT-on-extCtl instruction, and HALT/FAULT states.
//  Sits between the board-level IRAM/monitor logic and the 7-segment/LED display path.
// PARAMETERS
//  WIDTH          16  datapath/register width, >=16
//  IRAM_ADDR_BITS 8   instruction address width, 1..16; PC arithmetic is modulo 2**IRAM_ADDR_BITS
//  STACK_DEPTH    4   call-stack entries, >=1
// PORTS
//  clk        in   1               system clock, rising edge
//  reset      in   1               asynchronous, active-high; clears all state
//  PCenable   in   1               run enable; 0 freezes FSM, PC, regs, flags, stack
//  extCtl     in   1               external continue level, sampled in WAIT
//  imem_addr  out  IRAM_ADDR_BITS  IRAM read address (= PC)
//  imem_data  in   16              IRAM read data, valid 1 cycle after imem_addr
//  monRFSrc   in   4               register select for monitoring
//  monRFData  out  WIDTH           contents of R[monRFSrc], combinational
//  monInstr   out  16              latched instruction register
//  monPC      out  IRAM_ADDR_BITS  current PC
//  monFlags   out  4               {N,Z,C,V}
//  halted     out  1               1 in HALT state
//  fault      out  1               1 in FAULT state
// BEHAVIOUR
//  Reset: PC=0, IR=0, regs=0, flags=0, SP=0, state=FETCH; halted=fault=0; imem_addr=0.
//  Encoding: op=I[15:12] rd=I[11:8] rb=I[7:4] ra=I[3:0] imm=I[7:0]; off = sign-extended imm.
//  FSM (advances only when PCenable=1): FETCH -> EXEC; EXEC -> FETCH | WAIT | HALT | FAULT;
//   WAIT -> FETCH when extCtl=1 (PC+=1 on exit); HALT/FAULT are absorbing until reset.
//  FETCH: imem_addr=PC. EXEC: IR<=imem_data in the same edge that performs the write-back/PC update.
//   Implementation may register IR at end of FETCH and decode in EXEC: 2 cycles/instruction, fixed.
//  Ops (default PC<=PC+1):
//   0 NOP
//   1 ADD  rd=ra+rb
//   2 SUB  rd=ra-rb
//   3 AND
//   4 OR
//   5 LDL  rd={0,imm}
//   6 LDH  rd[15:8]=imm, other bits kept
//   7 BZ   if Z PC+=off
//   8 BNZ  if !Z PC+=off
//   9 BC   if C PC+=off
//   A JMP  PC+=off
//   B CALL push PC+1; PC+=off
//   C RET  PC=pop
//   D WAIT
//   E CMP  flags of ra-rb, no write
//   F HALT
//  Flags: only ADD/SUB/AND/OR/CMP update them.
//   Z=result==0. N=result[WIDTH-1].
//   ADD: C=carry-out, V=signed overflow. SUB/CMP: C=1 if no borrow (ra>=rb unsigned), V=signed overflow.
//   AND/OR: C,V unchanged.
//  Branch target = PC+off, wraps modulo IRAM size; off=0 is a tight self-loop.
//  Stack: CALL with SP==STACK_DEPTH -> FAULT, no push, PC held.
//   RET with SP==0 -> FAULT, PC held. Pushed value wraps (PC max +1 -> 0).
//  rd may equal ra/rb: operands read before write.
//  extCtl=1 already on WAIT entry: still spends >=1 cycle in WAIT.
//  PCenable=0 in any state: hold everything; monitors stay live.
//  Reset asserted mid-instruction: immediate return to reset values; no partial write survives.
// TESTING
//  T1: LDL R1,5; LDL R2,3; ADD R3,R1,R2 -> R3=8, Z=0, C=0; each instr takes exactly 2 enabled cycles.
//  T2: LDL R1,0; CMP R1,R1; BZ +3 at PC=2 -> PC=5. SUB R0=0-1 -> R0=0xFFFF, N=1, C=0.
//  T3: CALL +4 from PC=1 -> PC=5, SP=1; RET -> PC=2, SP=0; RET again -> fault=1, PC frozen.
//  T4: STACK_DEPTH=2, three nested CALLs -> fault on the third, SP=2.
//  T5: WAIT with extCtl=0 for 10 cycles -> PC unchanged; extCtl=1 -> PC+1 next FETCH. PCenable=0 mid-program freezes all state.
//  T6: HALT -> halted=1 forever; assert reset mid-EXEC of ADD -> dest reg=0, PC=0, state FETCH.

Source files
------------

// File: rtl/micro_mc.sv
// micro_mc: multi-cycle controller executing 16-bit instructions from a synchronous IRAM,
// with a 16-entry register file, N/Z/C/V flags, branches, a call stack, WAIT and HALT/FAULT.
module micro_mc #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned IRAM_ADDR_BITS = 8,
  parameter int unsigned STACK_DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      PCenable,
  input  logic                      extCtl,
  output logic [IRAM_ADDR_BITS-1:0] imem_addr,
  input  logic [15:0]               imem_data,
  input  logic [3:0]                monRFSrc,
  output logic [WIDTH-1:0]          monRFData,
  output logic [15:0]               monInstr,
  output logic [IRAM_ADDR_BITS-1:0] monPC,
  output logic [3:0]                monFlags,
  output logic                      halted,
  output logic                      fault
);
  localparam int unsigned AW    = IRAM_ADDR_BITS;
  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_LDL  = 4'h5;
  localparam logic [3:0] OP_LDH  = 4'h6;
  localparam logic [3:0] OP_BZ   = 4'h7;
  localparam logic [3:0] OP_BNZ  = 4'h8;
  localparam logic [3:0] OP_BC   = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_CALL = 4'hB;
  localparam logic [3:0] OP_RET  = 4'hC;
  localparam logic [3:0] OP_WAIT = 4'hD;
  localparam logic [3:0] OP_CMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_WAIT, S_HALT, S_FAULT} state_t;

  state_t            state, state_next;
  logic [AW-1:0]     pc, pc_next;
  logic [15:0]       ir;
  logic [3:0]        flags, flags_next;
  logic [SP_W-1:0]   sp, sp_next;
  logic [WIDTH-1:0]  regs [16];
  logic [AW-1:0]     stack [STACK_DEPTH];

  logic              rf_we;
  logic [WIDTH-1:0]  rf_wd;
  logic              push_en;
  logic              ir_load;

  // Decode straight from the IRAM output during EXEC; IR is a copy for monitoring.
  logic [3:0]        op, rd, rb, ra;
  logic [7:0]        imm;
  logic [15:0]       off16;
  logic [WIDTH-1:0]  ra_val, rb_val, rd_val;
  logic [AW-1:0]     pc_inc, pc_br;
  logic [IDX_W-1:0]  push_idx, pop_idx;

  assign op       = imem_data[15:12];
  assign rd       = imem_data[11:8];
  assign rb       = imem_data[7:4];
  assign ra       = imem_data[3:0];
  assign imm      = imem_data[7:0];
  assign off16    = {{8{imm[7]}}, imm};
  assign ra_val   = regs[ra];
  assign rb_val   = regs[rb];
  assign rd_val   = regs[rd];
  assign pc_inc   = pc + AW'(1);
  assign pc_br    = pc + AW'(off16);
  assign push_idx = IDX_W'(sp);
  assign pop_idx  = IDX_W'(sp - SP_W'(1));

  logic [WIDTH:0]    add_full, sub_full;
  logic              add_v, sub_v;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_c, alu_v;

  assign add_full = {1'b0, ra_val} + {1'b0, rb_val};
  assign sub_full = {1'b0, ra_val} - {1'b0, rb_val};
  assign add_v    = (ra_val[WIDTH-1] == rb_val[WIDTH-1]) && (add_full[WIDTH-1] != ra_val[WIDTH-1]);
  assign sub_v    = (ra_val[WIDTH-1] != rb_val[WIDTH-1]) && (sub_full[WIDTH-1] != ra_val[WIDTH-1]);

  // ALU result and carry/overflow; logic ops leave C and V as they were.
  always_comb begin
    alu_res = '0;
    alu_c   = flags[1];
    alu_v   = flags[0];
    case (op)
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = add_v;
      end
      OP_SUB, OP_CMP: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = ~sub_full[WIDTH];
        alu_v   = sub_v;
      end
      OP_AND:  alu_res = ra_val & rb_val;
      OP_OR:   alu_res = ra_val | rb_val;
      default: ;
    endcase
  end

  // Next-state, PC, flags, stack and write-back control.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    flags_next = flags;
    sp_next    = sp;
    rf_we      = 1'b0;
    rf_wd      = alu_res;
    push_en    = 1'b0;
    ir_load    = 1'b0;
    if (PCenable) begin
      case (state)
        S_FETCH: state_next = S_EXEC;
        S_EXEC: begin
          ir_load    = 1'b1;
          state_next = S_FETCH;
          pc_next    = pc_inc;
          case (op)
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              rf_we      = 1'b1;
              flags_next = {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
            end
            OP_CMP: flags_next = {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
            OP_LDL: begin
              rf_we = 1'b1;
              rf_wd = WIDTH'(imm);
            end
            OP_LDH: begin
              rf_we = 1'b1;
              rf_wd = (rd_val & ~WIDTH'(16'hFF00)) | (WIDTH'(imm) << 8);
            end
            OP_BZ:  if (flags[2])  pc_next = pc_br;
            OP_BNZ: if (!flags[2]) pc_next = pc_br;
            OP_BC:  if (flags[1])  pc_next = pc_br;
            OP_JMP: pc_next = pc_br;
            OP_CALL: begin
              if (sp == SP_W'(STACK_DEPTH)) begin
                state_next = S_FAULT;
                pc_next    = pc;
              end else begin
                push_en = 1'b1;
                sp_next = sp + SP_W'(1);
                pc_next = pc_br;
              end
            end
            OP_RET: begin
              if (sp == '0) begin
                state_next = S_FAULT;
                pc_next    = pc;
              end else begin
                sp_next = sp - SP_W'(1);
                pc_next = stack[pop_idx];
              end
            end
            OP_WAIT: begin
              state_next = S_WAIT;
              pc_next    = pc;
            end
            OP_HALT: begin
              state_next = S_HALT;
              pc_next    = pc;
            end
          endcase
        end
        S_WAIT: begin
          if (extCtl) begin
            state_next = S_FETCH;
            pc_next    = pc_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Architectural state and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= '0;
      ir     <= '0;
      flags  <= '0;
      sp     <= '0;
      halted <= 1'b0;
      fault  <= 1'b0;
    end else begin
      pc     <= pc_next;
      flags  <= flags_next;
      sp     <= sp_next;
      halted <= (state_next == S_HALT);
      fault  <= (state_next == S_FAULT);
      if (ir_load) ir <= imem_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (rf_we) begin
      regs[rd] <= rf_wd;
    end
  end

  // Return addresses wrap naturally at the top of the IRAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(STACK_DEPTH); i++) stack[i] <= '0;
    end else if (push_en) begin
      stack[push_idx] <= pc_inc;
    end
  end

  assign imem_addr = pc;
  assign monPC     = pc;
  assign monInstr  = ir;
  assign monFlags  = flags;
  assign monRFData = regs[monRFSrc];

endmodule

// File: tb/tb_micro_mc.sv
// Bench for micro_mc: instruction-level reference model checked every cycle, plus
// directed programs with hand-computed expectations and randomized programs.
module tb_micro_mc;
  localparam int AB    = 5;
  localparam int DEPTH = 2;
  localparam int MASK  = (1 << AB) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          PCenable;
  logic          extCtl;
  logic [AB-1:0] imem_addr;
  logic [15:0]   imem_data;
  logic [3:0]    monRFSrc;
  logic [15:0]   monRFData;
  logic [15:0]   monInstr;
  logic [AB-1:0] monPC;
  logic [3:0]    monFlags;
  logic          halted;
  logic          fault;

  micro_mc #(.WIDTH(16), .IRAM_ADDR_BITS(AB), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .PCenable(PCenable), .extCtl(extCtl),
    .imem_addr(imem_addr), .imem_data(imem_data), .monRFSrc(monRFSrc),
    .monRFData(monRFData), .monInstr(monInstr), .monPC(monPC),
    .monFlags(monFlags), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  // Synchronous IRAM
  logic [15:0] mem [32];
  logic [15:0] imem_q = 16'h0;
  always @(posedge clk) imem_q <= mem[imem_addr];
  assign imem_data = imem_q;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0=fetch 1=exec 2=wait 3=halt 4=fault
  int          m_pc;
  int          m_ph;
  logic [15:0] m_ir;
  logic [3:0]  m_fl;
  logic [15:0] m_r [16];
  int          m_stk [$];

  task automatic model_reset();
    m_pc = 0; m_ph = 0; m_ir = 16'h0; m_fl = 4'h0;
    for (int i = 0; i < 16; i++) m_r[i] = 16'h0;
    m_stk.delete();
  endtask

  task automatic set_nz(input int res);
    m_fl[3] = res[15];
    m_fl[2] = (res[15:0] == 16'h0);
  endtask

  task automatic model_exec(input logic [15:0] ins);
    logic [3:0] op, rd, rb, ra;
    logic [7:0] imm;
    int ua, ub, sa, sb, u, s, off, br, nxt;
    op = ins[15:12]; rd = ins[11:8]; rb = ins[7:4]; ra = ins[3:0]; imm = ins[7:0];
    ua = int'(m_r[ra]); ub = int'(m_r[rb]);
    sa = int'($signed(m_r[ra])); sb = int'($signed(m_r[rb]));
    off = int'($signed(imm));
    br  = (m_pc + off) & MASK;
    nxt = (m_pc + 1) & MASK;
    m_ir = ins;
    m_ph = 0;
    case (op)
      4'h1: begin
        u = ua + ub; s = sa + sb;
        m_r[rd] = u[15:0]; set_nz(u);
        m_fl[1] = (u > 65535); m_fl[0] = (s > 32767) || (s < -32768);
      end
      4'h2, 4'hE: begin
        u = ua - ub; s = sa - sb;
        if (op == 4'h2) m_r[rd] = u[15:0];
        set_nz(u);
        m_fl[1] = (ua >= ub); m_fl[0] = (s > 32767) || (s < -32768);
      end
      4'h3: begin u = ua & ub; m_r[rd] = u[15:0]; set_nz(u); end
      4'h4: begin u = ua | ub; m_r[rd] = u[15:0]; set_nz(u); end
      4'h5: m_r[rd] = {8'h00, imm};
      4'h6: m_r[rd] = {imm, m_r[rd][7:0]};
      4'h7: if (m_fl[2])  nxt = br;
      4'h8: if (!m_fl[2]) nxt = br;
      4'h9: if (m_fl[1])  nxt = br;
      4'hA: nxt = br;
      4'hB: begin
        if (m_stk.size() == DEPTH) begin m_ph = 4; nxt = m_pc; end
        else begin m_stk.push_back((m_pc + 1) & MASK); nxt = br; end
      end
      4'hC: begin
        if (m_stk.size() == 0) begin m_ph = 4; nxt = m_pc; end
        else nxt = m_stk.pop_back();
      end
      4'hD: begin m_ph = 2; nxt = m_pc; end
      4'hF: begin m_ph = 3; nxt = m_pc; end
      default: ;
    endcase
    m_pc = nxt;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else if (PCenable) begin
      case (m_ph)
        0: m_ph = 1;
        1: model_exec(mem[m_pc]);
        2: if (extCtl) begin m_pc = (m_pc + 1) & MASK; m_ph = 0; end
        default: ;
      endcase
    end
  end

  // Every-cycle comparison against the model
  always begin
    @(posedge clk);
    #2;
    chk("pc", 32'(monPC), 32'(m_pc));
    chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("instr", 32'(monInstr), 32'(m_ir));
    chk("flags", 32'(monFlags), 32'(m_fl));
    chk("halted", 32'(halted), 32'(m_ph == 3));
    chk("fault", 32'(fault), 32'(m_ph == 4));
    chk("rf_mon", 32'(monRFData), 32'(m_r[monRFSrc]));
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    reset = 1'b1;
    PCenable = 1'b1;
    extCtl = 1'b0;
  endtask

  task automatic release_reset();
    run(2);
    reset = 1'b0;
  endtask

  task automatic rd_reg(input string name, input logic [3:0] idx, input logic [15:0] exp);
    monRFSrc = idx;
    #1;
    chk(name, 32'(monRFData), 32'(exp));
  endtask

  initial begin
    reset = 1'b1; PCenable = 1'b0; extCtl = 1'b0; monRFSrc = 4'h0;
    clear_mem();
    run(2);
    chk("reset_pc", 32'(monPC), 32'h0);
    chk("reset_halted", 32'(halted), 32'h0);
    chk("reset_fault", 32'(fault), 32'h0);

    // T1: LDL/LDL/ADD, two cycles per instruction
    hold_reset(); clear_mem();
    mem[0] = 16'h5105; mem[1] = 16'h5203; mem[2] = 16'h1321; mem[3] = 16'hF000;
    release_reset();
    run(2); chk("t1_pc_after_1", 32'(monPC), 32'd1);
    run(2); chk("t1_pc_after_2", 32'(monPC), 32'd2);
    run(2); chk("t1_pc_after_3", 32'(monPC), 32'd3);
    rd_reg("t1_r3", 4'd3, 16'd8);
    chk("t1_flags", 32'(monFlags), 32'h0);
    run(2); chk("t1_halted", 32'(halted), 32'h1);

    // T2: CMP equal, BZ taken, SUB 0-1
    hold_reset(); clear_mem();
    mem[0] = 16'h5100; mem[1] = 16'hE011; mem[2] = 16'h7003;
    mem[5] = 16'h5201; mem[6] = 16'h2021; mem[7] = 16'hF000;
    release_reset();
    run(6); chk("t2_bz_pc", 32'(monPC), 32'd5);
    run(4); rd_reg("t2_r0", 4'd0, 16'hFFFF);
    chk("t2_flags", 32'(monFlags), 32'h8);

    // T3: CALL/RET and RET underflow
    hold_reset(); clear_mem();
    mem[1] = 16'hB004; mem[5] = 16'hC000; mem[2] = 16'hC000;
    release_reset();
    run(4); chk("t3_call_pc", 32'(monPC), 32'd5);
    run(2); chk("t3_ret_pc", 32'(monPC), 32'd2);
    run(2); chk("t3_fault", 32'(fault), 32'h1);
    run(6); chk("t3_pc_frozen", 32'(monPC), 32'd2);
    chk("t3_fault_kept", 32'(fault), 32'h1);

    // T4: stack overflow on the third nested CALL
    hold_reset(); clear_mem();
    mem[0] = 16'hB001; mem[1] = 16'hB001; mem[2] = 16'hB001;
    release_reset();
    run(4); chk("t4_no_fault_yet", 32'(fault), 32'h0);
    run(2); chk("t4_fault", 32'(fault), 32'h1);
    chk("t4_pc", 32'(monPC), 32'd2);

    // T5: WAIT on extCtl, then PCenable freeze mid-instruction
    hold_reset(); clear_mem();
    mem[0] = 16'h5107; mem[1] = 16'hD000; mem[2] = 16'h5209; mem[3] = 16'hF000;
    release_reset();
    run(4); run(10); chk("t5_wait_pc", 32'(monPC), 32'd1);
    extCtl = 1'b1;
    run(1); chk("t5_exit_pc", 32'(monPC), 32'd2);
    extCtl = 1'b0;
    run(1);
    PCenable = 1'b0;
    run(5); rd_reg("t5_frozen_r2", 4'd2, 16'd0);
    chk("t5_frozen_pc", 32'(monPC), 32'd2);
    PCenable = 1'b1;
    run(1); rd_reg("t5_resumed_r2", 4'd2, 16'd9);
    chk("t5_resumed_pc", 32'(monPC), 32'd3);

    // T6: reset during EXEC of ADD, then HALT is absorbing
    hold_reset(); clear_mem();
    mem[0] = 16'h5102; mem[1] = 16'h5203; mem[2] = 16'h1321; mem[3] = 16'hF000;
    release_reset();
    run(5);
    reset = 1'b1;
    rd_reg("t6_r3_after_reset", 4'd3, 16'd0);
    rd_reg("t6_r1_after_reset", 4'd1, 16'd0);
    chk("t6_pc_after_reset", 32'(monPC), 32'd0);
    chk("t6_ir_after_reset", 32'(monInstr), 32'd0);
    release_reset();
    run(8); rd_reg("t6_r3", 4'd3, 16'd5);
    chk("t6_halted", 32'(halted), 32'h1);
    run(20); chk("t6_halted_kept", 32'(halted), 32'h1);

    // Randomized programs, inputs and monitor selects
    for (int p = 0; p < 24; p++) begin
      hold_reset();
      for (int i = 0; i < 32; i++) begin
        logic [15:0] w;
        w = 16'($urandom);
        if (w[15:12] == 4'hF && $urandom_range(0, 3) != 0) w[15:12] = 4'h5;
        if (w[15:12] == 4'hC && $urandom_range(0, 1) != 0) w[15:12] = 4'h1;
        mem[i] = w;
      end
      release_reset();
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        PCenable = ($urandom_range(0, 9) < 8);
        extCtl   = ($urandom_range(0, 3) == 0);
        monRFSrc = 4'($urandom_range(0, 15));
        if (halted || fault) break;
      end
      run(4);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
